// File: rtl/routing_cfg_loader_pkg.sv
// Shared types and constants for the routing configuration loader.
// Frame layout: sync byte, payload bytes, XOR checksum byte.
package routing_cfg_pkg;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHKSUM,
        CHECK
    } cfg_state_e;

    localparam logic [7:0] IDENTITY_ROUTE = 8'hE4;
    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam logic [7:0] CHK_SEED_DEF   = 8'h5A;
    localparam logic [7:0] RESET_CFG_DEF  = IDENTITY_ROUTE;

    function automatic int cnt_width(input int payload_bytes);
        return $clog2(8 * payload_bytes);
    endfunction

endpackage

// File: rtl/routing_cfg_loader_if.sv
// Bit-serial configuration stream with valid/ready handshake and abort.
// The loader sits on the slave side.
interface routing_cfg_loader_if;

    logic cfg_data;
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_abort;

    modport master (
        output cfg_data,
        output cfg_valid,
        output cfg_abort,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        input  cfg_abort,
        output cfg_ready
    );

endinterface

// File: rtl/routing_cfg_loader_checksum.sv
// XOR of a seed with every byte lane of a payload word.
// Purely combinational.
module cfg_checksum #(
    parameter int PAYLOAD_BYTES = 1
) (
    input  logic [7:0]                 seed_i,
    input  logic [8*PAYLOAD_BYTES-1:0] data_i,
    output logic [7:0]                 sum_o
);

    always_comb begin
        sum_o = seed_i;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            sum_o = sum_o ^ data_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/routing_cfg_loader.sv
// Serial loader for the routing BitFile: hunts sync, shifts payload and
// checksum, commits only validated frames to the held cfg_word.
module routing_cfg_loader
    import routing_cfg_pkg::*;
#(
    parameter int                         PAYLOAD_BYTES = 1,
    parameter logic [7:0]                 SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter logic [7:0]                 CHK_SEED      = CHK_SEED_DEF,
    parameter logic [8*PAYLOAD_BYTES-1:0] RESET_CFG     =
        (8*PAYLOAD_BYTES)'(RESET_CFG_DEF)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    routing_cfg_loader_if.slave          cfg,
    output logic [8*PAYLOAD_BYTES-1:0]   cfg_word,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic                         cfg_loaded,
    output logic [3:0]                   err_cnt
);

    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int CW = cnt_width(PAYLOAD_BYTES);
    localparam logic [CW-1:0] PAY_LAST = CW'(PW - 1);
    localparam logic [CW-1:0] CHK_LAST = CW'(7);

    cfg_state_e    state_q, state_d;
    logic [7:0]    win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] shadow_q, shadow_d;
    logic [7:0]    chk_q, chk_d;
    logic [PW-1:0] word_q, word_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          loaded_q, loaded_d;
    logic [3:0]    ecnt_q, ecnt_d;

    logic          ready;
    logic          accept;
    logic [7:0]    calc;
    logic [7:0]    win_nxt;

    cfg_checksum #(
        .PAYLOAD_BYTES(PAYLOAD_BYTES)
    ) u_chk (
        .seed_i (CHK_SEED),
        .data_i (shadow_q),
        .sum_o  (calc)
    );

    assign ready         = (state_q != CHECK);
    assign accept        = cfg.cfg_valid && ready;
    assign win_nxt       = {win_q[6:0], cfg.cfg_data};
    assign cfg.cfg_ready = ready;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        chk_d    = chk_q;
        word_d   = word_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        loaded_d = loaded_q;
        ecnt_d   = ecnt_q;

        // Abort outranks everything, including the commit in CHECK.
        if (cfg.cfg_abort) begin
            state_d = HUNT;
            win_d   = '0;
            cnt_d   = '0;
            chk_d   = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (accept) begin
                        win_d = win_nxt;
                        if (win_nxt == SYNC_BYTE) begin
                            state_d = PAYLOAD;
                            win_d   = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        shadow_d = {shadow_q[PW-2:0], cfg.cfg_data};
                        if (cnt_q == PAY_LAST) begin
                            state_d = CHKSUM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                CHKSUM: begin
                    if (accept) begin
                        chk_d = {chk_q[6:0], cfg.cfg_data};
                        if (cnt_q == CHK_LAST) begin
                            state_d = CHECK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    state_d = HUNT;
                    if (chk_q == calc) begin
                        word_d   = shadow_q;
                        done_d   = 1'b1;
                        loaded_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (ecnt_q != 4'hF) begin
                            ecnt_d = ecnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            win_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            chk_q    <= '0;
            word_q   <= RESET_CFG;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            chk_q    <= chk_d;
            word_q   <= word_d;
            done_q   <= done_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign cfg_word   = word_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign cfg_loaded = loaded_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_routing_cfg_loader.sv
// Directed bench for routing_cfg_loader: framing, checksum, abort,
// saturation and reset behaviour against hand-computed values.
module tb_routing_cfg_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] cfg_word;
    logic       cfg_done;
    logic       cfg_err;
    logic       cfg_loaded;
    logic [3:0] err_cnt;

    int checks;
    int failures;
    int done_cnt;
    int err_pulses;
    int both_cnt;
    int rdy_low;
    int d0;
    int e0;
    int r0;

    routing_cfg_loader_if cfg_if ();

    routing_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg_if),
        .cfg_word   (cfg_word),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .cfg_loaded (cfg_loaded),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_done) done_cnt++;
            if (cfg_err) err_pulses++;
            if (cfg_done && cfg_err) both_cnt++;
            if (!cfg_if.cfg_ready) rdy_low++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int guard;
        guard = 0;
        while (!cfg_if.cfg_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!cfg_if.cfg_ready) chk("ready_timeout", 32'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_data  = b;
        cfg_if.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_bit(v[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] p, input logic [7:0] c,
                              input int gap);
        send_byte(8'hA5, gap);
        send_byte(p, gap);
        send_byte(c, gap);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        err_pulses = 0;
        both_cnt   = 0;
        rdy_low    = 0;
        rst_n            = 1'b0;
        cfg_if.cfg_data  = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_abort = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        chk("rst_word", 32'(cfg_word), 32'hE4);
        chk("rst_loaded", 32'(cfg_loaded), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
        chk("rst_done", 32'(cfg_done), 0);

        // Good frame
        d0 = done_cnt;
        r0 = rdy_low;
        send_frame(8'h1B, 8'h41, 0);
        chk("good_ready_check", 32'(cfg_if.cfg_ready), 0);
        chk("good_word_hold", 32'(cfg_word), 32'hE4);
        idle(1);
        chk("good_word", 32'(cfg_word), 32'h1B);
        chk("good_done", 32'(cfg_done), 1);
        chk("good_loaded", 32'(cfg_loaded), 1);
        idle(3);
        chk("good_done_once", 32'(done_cnt - d0), 1);
        chk("good_ready_low", 32'(rdy_low - r0), 1);

        // Bad checksum
        d0 = done_cnt;
        e0 = err_pulses;
        send_frame(8'h1B, 8'h40, 0);
        idle(1);
        chk("bad_err", 32'(cfg_err), 1);
        chk("bad_errcnt", 32'(err_cnt), 1);
        chk("bad_word", 32'(cfg_word), 32'h1B);
        idle(2);
        chk("bad_err_once", 32'(err_pulses - e0), 1);
        chk("bad_no_done", 32'(done_cnt - d0), 0);

        // Garbage prefix with random valid gaps
        d0 = done_cnt;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_frame(8'h27, 8'h7D, 3);
        idle(3);
        chk("hunt_word", 32'(cfg_word), 32'h27);
        chk("hunt_done_once", 32'(done_cnt - d0), 1);

        // Abort mid-payload, drop the simultaneous bit, then full frame
        d0 = done_cnt;
        e0 = err_pulses;
        send_byte(8'hA5, 0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        cfg_if.cfg_abort = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 1'b1;
        @(negedge clk);
        cfg_if.cfg_abort = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 1'b0;
        send_frame(8'h9C, 8'hC6, 0);
        idle(3);
        chk("abort_word", 32'(cfg_word), 32'h9C);
        chk("abort_no_err", 32'(err_pulses - e0), 0);
        chk("abort_errcnt", 32'(err_cnt), 1);
        chk("abort_done_once", 32'(done_cnt - d0), 1);

        // Abort landing in CHECK suppresses an otherwise good commit
        d0 = done_cnt;
        send_frame(8'h11, 8'h4B, 0);
        cfg_if.cfg_abort = 1'b1;
        @(negedge clk);
        cfg_if.cfg_abort = 1'b0;
        idle(3);
        chk("chkabort_word", 32'(cfg_word), 32'h9C);
        chk("chkabort_no_done", 32'(done_cnt - d0), 0);
        chk("chkabort_ready", 32'(cfg_if.cfg_ready), 1);

        // Error saturation
        e0 = err_pulses;
        for (int f = 0; f < 17; f++) begin
            send_frame(8'h00, 8'h00, 0);
            if (f == 12) begin
                idle(1);
                chk("sat_errcnt_mid", 32'(err_cnt), 14);
            end
        end
        idle(2);
        chk("sat_errcnt", 32'(err_cnt), 15);
        chk("sat_err_pulses", 32'(err_pulses - e0), 17);
        chk("sat_word", 32'(cfg_word), 32'h9C);

        // Reset mid-payload
        send_byte(8'hA5, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_word", 32'(cfg_word), 32'hE4);
        chk("mid_rst_errcnt", 32'(err_cnt), 0);
        chk("mid_rst_loaded", 32'(cfg_loaded), 0);

        // Remaining payload bits must not complete a frame after reset
        d0 = done_cnt;
        send_byte(8'h1B, 0);
        send_byte(8'h41, 0);
        idle(3);
        chk("post_rst_no_done", 32'(done_cnt - d0), 0);
        send_frame(8'h3C, 8'h66, 0);
        idle(2);
        chk("post_rst_word", 32'(cfg_word), 32'h3C);
        chk("never_both", 32'(both_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/routing_cfg_loader.md
Name: routing_cfg_loader

Overview:
- Serial configuration loader that produces the 8-bit routing BitFile consumed by the Routing_Channel interconnect.
- Receives a framed, bit-serial bitstream over a valid/ready handshake and hunts for a sync byte.
- Deserializes the payload and checks an XOR checksum. On a good checksum it commits the payload atomically to a held configuration register.
- The interconnect only ever sees a complete, validated configuration; it never sees one that is partially shifted.

Parameters:
- PAYLOAD_BYTES, 1: number of payload bytes per frame. Byte-lane 0 is the routing BitFile.
- SYNC_BYTE, 8'hA5: frame start marker.
- CHK_SEED, 8'h5A: checksum seed.
- RESET_CFG, 8'hE4 zero-extended to 8*PAYLOAD_BYTES: identity routing (A->A, B->B, C->C, D->D).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active low
- cfg_data  in  1  serial bitstream bit, MSB first
- cfg_valid  in  1  cfg_data is valid this cycle
- cfg_ready  out  1  loader accepts a bit this cycle
- cfg_abort  in  1  synchronous abort of the frame in progress
- cfg_word  out  8*PAYLOAD_BYTES  committed configuration; [7:0] drives BitFile
- cfg_done  out  1  one-cycle pulse on commit
- cfg_err  out  1  one-cycle pulse on checksum mismatch
- cfg_loaded  out  1  sticky; set after the first successful commit
- err_cnt  out  4  saturating count of checksum errors

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=HUNT; cfg_word=RESET_CFG; cfg_done=0, cfg_err=0, cfg_loaded=0, err_cnt=0.
  - Shift window and counters cleared.
  - Reset mid-frame discards the frame.
- Bit accept: a bit is accepted on an edge where cfg_valid && cfg_ready. cfg_ready=1 in HUNT, PAYLOAD and CHKSUM; cfg_ready=0 in CHECK.
- States:
  - HUNT:
    - Each accepted bit shifts into an 8-bit window: win <= {win[6:0], cfg_data}.
    - If {win[6:0], cfg_data}==SYNC_BYTE, go to PAYLOAD and clear win and bit_cnt.
    - Overlapping or garbage prefixes are tolerated.
  - PAYLOAD:
    - Accepted bits shift into shadow[8*PAYLOAD_BYTES-1:0], MSB first. The first bit ends at the MSB.
    - bit_cnt counts 0..8*PAYLOAD_BYTES-1. On the last bit, go to CHKSUM with bit_cnt=0.
  - CHKSUM:
    - 8 accepted bits shift into chk, MSB first.
    - On the 8th bit, go to CHECK.
  - CHECK (exactly one cycle, no bit accepted):
    - calc = CHK_SEED XOR all payload bytes of shadow.
    - If chk==calc: cfg_word<=shadow, cfg_done<=1, cfg_loaded<=1.
    - Else: cfg_err<=1 and err_cnt<=err_cnt+1, saturating at 15. cfg_word is unchanged.
    - Always return to HUNT.
- Latency: last checksum bit accepted at edge N. CHECK is the state during cycle N..N+1. The new cfg_word and cfg_done are visible after edge N+1.
- cfg_done and cfg_err are registered, high for exactly one cycle, and never both high.
- cfg_valid low: no state change. Gaps of any length are allowed in any state.
- cfg_abort=1 (priority below reset, above everything else):
  - Next state HUNT; win, bit_cnt and chk cleared.
  - No commit, no cfg_err, and err_cnt unchanged. This applies even in CHECK.
  - An abort with a simultaneous valid bit drops that bit.
- cfg_word changes only on a successful commit or on reset. It never shows partial data.
- Back-to-back frames: the sync hunt resumes the cycle after CHECK. Bits offered during CHECK are not accepted, because ready=0.

Decomposition:
- Package routing_cfg_pkg holds:
  - the state enum (HUNT, PAYLOAD, CHKSUM, CHECK);
  - SYNC_BYTE, CHK_SEED and RESET_CFG defaults;
  - an identity-routing constant 8'hE4;
  - a function for the bit_cnt width, clog2(8*PAYLOAD_BYTES).
- One sub-module is natural: cfg_checksum. It is a combinational XOR reduction of the PAYLOAD_BYTES lanes with the seed, and is reusable by the bench model.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> cfg_word=8'hE4, cfg_loaded=0, err_cnt=0, cfg_ready=1.
- Good frame: send A5, 1B, 41 (5A^1B) continuously -> after CHECK, cfg_word=8'h1B, cfg_done pulses once, cfg_loaded=1; cfg_ready=0 for exactly one cycle.
- Bad checksum: send A5, 1B, 40 -> cfg_err pulses once, err_cnt=1, cfg_word stays at its previous value (E4 or 1B).
- Sync hunt with garbage prefix: send bits 1,1,0 then A5, 27, 7D, with random cfg_valid gaps of 0-3 cycles -> cfg_word=8'h27, exactly one cfg_done.
- Abort: send A5 and 4 payload bits, then cfg_abort for 1 cycle, then a full frame A5, 9C, C6 -> no err, err_cnt unchanged, final cfg_word=8'h9C.
- Error saturation: 17 consecutive bad frames -> err_cnt holds 15; reset mid-payload in the next frame -> cfg_word=E4, err_cnt=0.
